// File: rtl/sobel_edge_3x3_if.sv
// Video stream bundle for the Sobel stage: three aligned row taps plus frame sync in,
// one edge pixel plus delayed frame sync out. The DUT side uses the slave modport.
interface sobel_edge_3x3_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              per_frame_vsync;
  logic              per_frame_href;
  logic              per_frame_clken;
  logic [DATA_W-1:0] taps0x;
  logic [DATA_W-1:0] taps1x;
  logic [DATA_W-1:0] taps2x;

  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic [DATA_W-1:0] post_img_edge;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, taps0x, taps1x, taps2x,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_edge
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, taps0x, taps1x, taps2x,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_edge
  );

endinterface

// File: rtl/sobel_edge_3x3.sv
// 3x3 Sobel edge magnitude |Gx|+|Gy| with a fixed 4-cycle pipeline and frame border masking.
// Optional macro SOBEL_THRESHOLD_EN: output becomes binary (sum > THRESHOLD) instead of the
// saturated magnitude.
module sobel_edge_3x3 #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] THRESHOLD = DATA_W'(64)
) (
  input logic               clock,
  input logic               rst_n,
  sobel_edge_3x3_if.slave   bus
);

  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned TOT_W = DATA_W + 3;

  // S1 window: mRC, R = window row (1 = oldest line), C = column (1 = oldest pixel)
  logic [DATA_W-1:0] m11_q, m12_q, m13_q;
  logic [DATA_W-1:0] m21_q, m22_q, m23_q;
  logic [DATA_W-1:0] m31_q, m32_q, m33_q;
  logic              border_s1_q, border_s2_q, border_s3_q;

  logic [1:0] col_q, row_q;
  logic       vsync_prev_q, href_prev_q;
  logic       vsync_rise, href_fall;

  logic [SUM_W-1:0]  gx_p_d, gx_n_d, gy_p_d, gy_n_d;
  logic [SUM_W-1:0]  gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [SUM_W-1:0]  gx_d, gy_d, gx_q, gy_q;
  logic [TOT_W-1:0]  sum;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] edge_q;

  logic [3:0] vsync_dly_q, href_dly_q, clken_dly_q;

  assign vsync_rise = bus.per_frame_vsync & ~vsync_prev_q;
  assign href_fall  = href_prev_q & ~bus.per_frame_href;

  // Edge-detect history for vsync/href
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
    end else begin
      vsync_prev_q <= bus.per_frame_vsync;
      href_prev_q  <= bus.per_frame_href;
    end
  end

  // Column position within the line, saturating at 2 (first two pixels are border)
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= 2'd0;
    end else if (!bus.per_frame_href) begin
      col_q <= 2'd0;
    end else if (bus.per_frame_clken && col_q != 2'd2) begin
      col_q <= col_q + 2'd1;
    end
  end

  // Line position within the frame; vsync rise takes priority over a coincident href fall
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 2'd0;
    end else if (vsync_rise) begin
      row_q <= 2'd0;
    end else if (href_fall && row_q != 2'd2) begin
      row_q <= row_q + 2'd1;
    end
  end

  // S1: shift the window left on each pixel strobe and tag the pixel as border or not
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      {m11_q, m12_q, m13_q} <= '0;
      {m21_q, m22_q, m23_q} <= '0;
      {m31_q, m32_q, m33_q} <= '0;
      border_s1_q           <= 1'b0;
    end else if (bus.per_frame_clken) begin
      {m11_q, m12_q, m13_q} <= {m12_q, m13_q, bus.taps0x};
      {m21_q, m22_q, m23_q} <= {m22_q, m23_q, bus.taps1x};
      {m31_q, m32_q, m33_q} <= {m32_q, m33_q, bus.taps2x};
      border_s1_q           <= (col_q < 2'd2) || (row_q < 2'd2);
    end
  end

  // S2 partial sums; the centre pixel carries zero weight in both kernels
  always_comb begin
    gx_p_d = SUM_W'(m13_q) + (SUM_W'(m23_q) << 1) + SUM_W'(m33_q);
    gx_n_d = SUM_W'(m11_q) + (SUM_W'(m21_q) << 1) + SUM_W'(m31_q);
    gy_p_d = SUM_W'(m31_q) + (SUM_W'(m32_q) << 1) + SUM_W'(m33_q);
    gy_n_d = SUM_W'(m11_q) + (SUM_W'(m12_q) << 1) + SUM_W'(m13_q);
  end

  // S2 register stage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gx_p_q      <= '0;
      gx_n_q      <= '0;
      gy_p_q      <= '0;
      gy_n_q      <= '0;
      border_s2_q <= 1'b0;
    end else begin
      gx_p_q      <= gx_p_d;
      gx_n_q      <= gx_n_d;
      gy_p_q      <= gy_p_d;
      gy_n_q      <= gy_n_d;
      border_s2_q <= border_s1_q;
    end
  end

  // S3 absolute differences by compare-and-select so no signed arithmetic is needed
  always_comb begin
    gx_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
    gy_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);
  end

  // S3 register stage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gx_q        <= '0;
      gy_q        <= '0;
      border_s3_q <= 1'b0;
    end else begin
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      border_s3_q <= border_s2_q;
    end
  end

  // S4 magnitude and output mapping
  always_comb begin
    sum = TOT_W'(gx_q) + TOT_W'(gy_q);
`ifdef SOBEL_THRESHOLD_EN
    result = (sum > TOT_W'(THRESHOLD)) ? {DATA_W{1'b1}} : '0;
`else
    result = (sum > TOT_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`endif
  end

`ifndef SOBEL_THRESHOLD_EN
  logic unused_threshold;
  assign unused_threshold = ^THRESHOLD;
`endif

  // S4 output register with border masking
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= border_s3_q ? '0 : result;
    end
  end

  // Sync delay lines run every cycle, independent of the pixel strobe
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly_q <= '0;
      href_dly_q  <= '0;
      clken_dly_q <= '0;
    end else begin
      vsync_dly_q <= {vsync_dly_q[2:0], bus.per_frame_vsync};
      href_dly_q  <= {href_dly_q[2:0], bus.per_frame_href};
      clken_dly_q <= {clken_dly_q[2:0], bus.per_frame_clken};
    end
  end

  assign bus.post_frame_vsync = vsync_dly_q[3];
  assign bus.post_frame_href  = href_dly_q[3];
  assign bus.post_frame_clken = clken_dly_q[3];
  assign bus.post_img_edge    = edge_q;

endmodule
